// File: rtl/cim_feeder_pkg.sv
// Shared types and constants for the CiM stream feeder: FSM state encoding,
// job image layout (phase lengths and base addresses) and phase helpers.
package cim_feeder_pkg;

  localparam int unsigned ACT_BEATS   = 12;
  localparam int unsigned WM_BEATS    = 128;
  localparam int unsigned WS_BEATS    = 32;
  localparam int unsigned TOTAL_BEATS = ACT_BEATS + WM_BEATS + WS_BEATS;

  // Source RAM addresses where each phase of the job image begins.
  localparam int unsigned ACT_BASE = 0;
  localparam int unsigned WM_BASE  = ACT_BASE + ACT_BEATS;
  localparam int unsigned WS_BASE  = WM_BASE + WM_BEATS;

  localparam int unsigned ADDR_W = 8;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND_ACT = 3'd1,
    SEND_WM  = 3'd2,
    SEND_WS  = 3'd3,
    WAIT_RES = 3'd4,
    DONE     = 3'd5
  } state_e;

  // One extra bit so base + count + 1 never wraps.
  typedef logic [ADDR_W:0] bidx_t;

  function automatic logic is_send(input state_e st);
    case (st)
      SEND_ACT, SEND_WM, SEND_WS: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

  // Image index of the first beat of the phase.
  function automatic bidx_t phase_base(input state_e st);
    case (st)
      SEND_ACT: return bidx_t'(ACT_BASE);
      SEND_WM:  return bidx_t'(WM_BASE);
      SEND_WS:  return bidx_t'(WS_BASE);
      default:  return bidx_t'(TOTAL_BEATS);
    endcase
  endfunction

  // Image index one past the last beat of the phase.
  function automatic bidx_t phase_end(input state_e st);
    case (st)
      SEND_ACT: return bidx_t'(WM_BASE);
      SEND_WM:  return bidx_t'(WS_BASE);
      SEND_WS:  return bidx_t'(TOTAL_BEATS);
      default:  return bidx_t'(TOTAL_BEATS);
    endcase
  endfunction

endpackage

// File: rtl/feeder_skid_fifo.sv
// Two-entry skid FIFO between the source RAM read port and the tx stream.
// Push and pop in the same cycle both take effect, leaving occupancy unchanged.
module feeder_skid_fifo #(
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic              empty_o,
  output logic [1:0]        occ_o
);

  logic [DATA_W-1:0] mem_q [2];
  logic              wr_ptr_q;
  logic              rd_ptr_q;
  logic [1:0]        occ_q;
  logic [1:0]        occ_d;
  logic              push_s;
  logic              pop_s;

  // Qualify push/pop against occupancy and compute next occupancy.
  always_comb begin
    pop_s  = pop_i & (occ_q != 2'd0);
    push_s = push_i & ((occ_q != 2'd2) | pop_s);
    case ({push_s, pop_s})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  // Storage, pointers and occupancy; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= push_data_i;
      end else begin
        mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
      end
      wr_ptr_q <= wr_ptr_q ^ push_s;
      rd_ptr_q <= rd_ptr_q ^ pop_s;
      occ_q    <= occ_d;
    end
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign empty_o = (occ_q == 2'd0);
  assign occ_o   = occ_q;

endmodule

// File: rtl/cim_stream_feeder.sv
// Host-side feeder for the CiM accelerator: streams a 172-beat job image
// (ACT, WM, WS phases) from a source RAM over valid/ready, then captures the
// accelerator's result beats into a result buffer.
// Optional build macro FEEDER_CHECKSUM_EN adds chk_o, the XOR of every tx
// beat accepted in the current job.
module cim_stream_feeder
  import cim_feeder_pkg::*;
#(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned RES_W     = 32,
  parameter int unsigned RES_BEATS = 8,
  localparam int unsigned RES_AW   = $clog2(RES_BEATS)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              src_ren_o,
  output logic [ADDR_W-1:0] src_raddr_o,
  input  logic [DATA_W-1:0] src_rdata_i,
  output logic              tx_valid_o,
  output logic [DATA_W-1:0] tx_data_o,
  input  logic              tx_ready_i,
  input  logic              rx_valid_i,
  input  logic [RES_W-1:0]  rx_data_i,
  output logic              rx_ready_o,
  output logic              res_wen_o,
  output logic [RES_AW-1:0] res_waddr_o,
  output logic [RES_W-1:0]  res_wdata_o
`ifdef FEEDER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chk_o
`endif
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] phase_cnt_q, phase_cnt_d;
  logic [ADDR_W-1:0] issue_q, issue_d;
  logic              inflight_q;
  logic [RES_AW-1:0] res_cnt_q, res_cnt_d;

  logic              send_s;
  logic              tx_valid_s;
  logic              tx_fire_s;
  logic              rx_ready_s;
  logic              rx_fire_s;
  logic              start_acc_s;
  logic [2:0]        slots_s;
  logic              src_ren_s;
  logic              phase_last_s;
  logic              res_last_s;

  logic [DATA_W-1:0] fifo_head_s;
  logic              fifo_empty_s;
  logic [1:0]        fifo_occ_s;

  // Read data is valid exactly one cycle after the read, so the in-flight flag
  // doubles as the FIFO push strobe; reset clears it and drops stale data.
  feeder_skid_fifo #(.DATA_W(DATA_W)) u_fifo (
    .clk         (clk),
    .rst_i       (rst_i),
    .push_i      (inflight_q),
    .push_data_i (src_rdata_i),
    .pop_i       (tx_fire_s),
    .head_o      (fifo_head_s),
    .empty_o     (fifo_empty_s),
    .occ_o       (fifo_occ_s)
  );

  // Handshake decode and read-issue gating.
  always_comb begin
    send_s      = is_send(state_q);
    tx_valid_s  = send_s & ~fifo_empty_s;
    tx_fire_s   = tx_valid_s & tx_ready_i;
    rx_ready_s  = (state_q == WAIT_RES);
    rx_fire_s   = rx_valid_i & rx_ready_s;
    start_acc_s = (state_q == IDLE) & start_i;
    // Slot budget counts the entry leaving this cycle as free so the FIFO can
    // sustain one beat per cycle while never holding more than two entries.
    slots_s     = {1'b0, fifo_occ_s} - {2'b00, tx_fire_s} + {2'b00, inflight_q};
    src_ren_s   = (send_s | start_acc_s) & (slots_s < 3'd2) &
                  (issue_q < ADDR_W'(TOTAL_BEATS));
    phase_last_s = ((phase_base(state_q) + {1'b0, phase_cnt_q} + bidx_t'(1)) ==
                    phase_end(state_q));
    res_last_s  = (res_cnt_q == RES_AW'(RES_BEATS - 1));
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     state_d = start_i ? SEND_ACT : IDLE;
      SEND_ACT: state_d = (tx_fire_s & phase_last_s) ? SEND_WM  : SEND_ACT;
      SEND_WM:  state_d = (tx_fire_s & phase_last_s) ? SEND_WS  : SEND_WM;
      SEND_WS:  state_d = (tx_fire_s & phase_last_s) ? WAIT_RES : SEND_WS;
      WAIT_RES: state_d = (rx_fire_s & res_last_s)   ? DONE     : WAIT_RES;
      DONE:     state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs and datapath pass-through.
  always_comb begin
    busy_o      = (state_q != IDLE) & (state_q != DONE);
    done_o      = (state_q == DONE);
    src_ren_o   = src_ren_s;
    src_raddr_o = issue_q;
    tx_valid_o  = tx_valid_s;
    tx_data_o   = fifo_head_s;
    rx_ready_o  = rx_ready_s;
    res_wen_o   = rx_fire_s;
    res_waddr_o = res_cnt_q;
    res_wdata_o = rx_data_i;
  end

  // Next values for phase, read-issue and result counters.
  always_comb begin
    if (state_d != state_q) begin
      phase_cnt_d = '0;
    end else if (tx_fire_s) begin
      phase_cnt_d = phase_cnt_q + ADDR_W'(1);
    end else begin
      phase_cnt_d = phase_cnt_q;
    end

    if (state_q == DONE) begin
      issue_d = '0;
    end else if (src_ren_s) begin
      issue_d = issue_q + ADDR_W'(1);
    end else begin
      issue_d = issue_q;
    end

    if (rx_fire_s) begin
      res_cnt_d = res_last_s ? '0 : res_cnt_q + RES_AW'(1);
    end else begin
      res_cnt_d = res_cnt_q;
    end
  end

  // Counter and in-flight registers.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      phase_cnt_q <= '0;
      issue_q     <= '0;
      inflight_q  <= 1'b0;
      res_cnt_q   <= '0;
    end else begin
      phase_cnt_q <= phase_cnt_d;
      issue_q     <= issue_d;
      inflight_q  <= src_ren_s;
      res_cnt_q   <= res_cnt_d;
    end
  end

`ifdef FEEDER_CHECKSUM_EN
  logic [DATA_W-1:0] chk_q;

  // Running XOR of accepted beats; cleared by an accepted start, held after DONE.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      chk_q <= '0;
    end else if (start_acc_s) begin
      chk_q <= '0;
    end else if (tx_fire_s) begin
      chk_q <= chk_q ^ fifo_head_s;
    end else begin
      chk_q <= chk_q;
    end
  end

  assign chk_o = chk_q;
`endif

endmodule

// File: tb/tb_cim_stream_feeder.sv
// Self-checking bench for cim_stream_feeder: a source RAM model, random
// tx/rx handshake pressure, and a job-level reference model (expected image
// order, address sequence, result sequence, done/busy timing).
module tb_cim_stream_feeder;

  localparam int NB = 172;
  localparam int NR = 8;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        busy_o;
  logic        done_o;
  logic        src_ren_o;
  logic [7:0]  src_raddr_o;
  logic [31:0] src_rdata_i;
  logic        tx_valid_o;
  logic [31:0] tx_data_o;
  logic        tx_ready_i;
  logic        rx_valid_i;
  logic [31:0] rx_data_i;
  logic        rx_ready_o;
  logic        res_wen_o;
  logic [2:0]  res_waddr_o;
  logic [31:0] res_wdata_o;
`ifdef FEEDER_CHECKSUM_EN
  logic [31:0] chk_o;
  logic [31:0] exp_chk;
`endif

  always #5 clk = ~clk;

  cim_stream_feeder dut (
    .clk         (clk),
    .rst_i       (rst_i),
    .start_i     (start_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .src_ren_o   (src_ren_o),
    .src_raddr_o (src_raddr_o),
    .src_rdata_i (src_rdata_i),
    .tx_valid_o  (tx_valid_o),
    .tx_data_o   (tx_data_o),
    .tx_ready_i  (tx_ready_i),
    .rx_valid_i  (rx_valid_i),
    .rx_data_i   (rx_data_i),
    .rx_ready_o  (rx_ready_o),
    .res_wen_o   (res_wen_o),
    .res_waddr_o (res_waddr_o),
    .res_wdata_o (res_wdata_o)
`ifdef FEEDER_CHECKSUM_EN
    ,
    .chk_o       (chk_o)
`endif
  );

  logic [31:0] src_mem [0:NB-1];

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int          beat_idx;
  int          exp_issue;
  int          res_idx;
  int          cyc_ctr = 0;
  int          start_cyc;
  int          first_valid_cyc;
  int          last_fire_cyc;
  int          jobs_done = 0;
  bit          job_active;
  bit          done_due;
  bit          prev_stall;
  logic [31:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    job_active = 1'b0;
    done_due   = 1'b0;
    prev_stall = 1'b0;
    beat_idx   = 0;
    exp_issue  = 0;
    res_idx    = 0;
  endtask

  // One clock cycle: inputs were set at posedge+1; sample and check on the
  // negedge, then emulate the 1-cycle-latency source RAM.
  task automatic cyc();
    logic       ren_s;
    logic [7:0] addr_s;
    bit         start_acc;
    bit         was_done;
    bit         exp_rr;
    bit         exp_wen;
    @(negedge clk);
    if (rst_i) begin
      reset_model();
    end else begin
      was_done  = done_due;
      start_acc = start_i && !job_active;
      exp_rr    = job_active && !was_done && (beat_idx == NB);
      chk("busy", 32'(busy_o), 32'(job_active && !was_done));
      chk("done", 32'(done_o), 32'(was_done));
      chk("rx_ready", 32'(rx_ready_o), 32'(exp_rr));
      if (start_acc) begin
        beat_idx        = 0;
        exp_issue       = 0;
        res_idx         = 0;
        start_cyc       = cyc_ctr;
        first_valid_cyc = -1;
        prev_stall      = 1'b0;
`ifdef FEEDER_CHECKSUM_EN
        exp_chk = 32'h0;
`endif
      end
      // source read address sequence
      if (src_ren_o) begin
        chk("raddr", 32'(src_raddr_o), 32'(exp_issue));
        chk("raddr_range", 32'(src_raddr_o < 8'd172), 32'd1);
        exp_issue++;
      end
      if (!job_active && !start_acc) chk("ren_idle", 32'(src_ren_o), 32'd0);
      // tx stream
      if (!job_active || beat_idx >= NB) chk("tx_idle", 32'(tx_valid_o), 32'd0);
      if (prev_stall) begin
        chk("hold_valid", 32'(tx_valid_o), 32'd1);
        chk("hold_data", tx_data_o, prev_data);
      end
      if (job_active && tx_valid_o === 1'b1 && first_valid_cyc < 0) first_valid_cyc = cyc_ctr;
      if (job_active && tx_valid_o === 1'b1 && tx_ready_i && beat_idx < NB) begin
        chk("tx_data", tx_data_o, src_mem[beat_idx]);
`ifdef FEEDER_CHECKSUM_EN
        exp_chk = exp_chk ^ src_mem[beat_idx];
`endif
        last_fire_cyc = cyc_ctr;
        beat_idx++;
      end
      prev_stall = job_active && (tx_valid_o === 1'b1) && !tx_ready_i;
      prev_data  = tx_data_o;
      // result capture
      exp_wen = rx_valid_i && exp_rr;
      chk("res_wen", 32'(res_wen_o), 32'(exp_wen));
      if (exp_wen) begin
        chk("res_waddr", 32'(res_waddr_o), 32'(res_idx));
        chk("res_wdata", res_wdata_o, 32'hA0 + 32'(res_idx));
        res_idx++;
        if (res_idx == NR) done_due = 1'b1;
      end
      if (was_done) begin
        job_active = 1'b0;
        done_due   = 1'b0;
        jobs_done++;
      end
      if (start_acc) job_active = 1'b1;
    end
    cyc_ctr++;
    ren_s  = src_ren_o;
    addr_s = src_raddr_o;
    @(posedge clk);
    #1;
    if (ren_s && addr_s < 8'd172) src_rdata_i = src_mem[addr_s];
    else src_rdata_i = $urandom;
  endtask

  // Run one job; optional tx stall at a given beat, optional reset abort.
  task automatic run_job(input int ready_pct, input int stall_at, input int rst_at,
                         input bit rnd_rx, output bit aborted);
    int stall_cnt;
    int jd0;
    bit fin;
    stall_cnt  = 0;
    jd0        = jobs_done;
    fin        = 1'b0;
    aborted    = 1'b0;
    start_i    = 1'b1;
    tx_ready_i = ($urandom_range(0, 99) < ready_pct);
    rx_valid_i = 1'b1;
    rx_data_i  = 32'hA0;
    cyc();
    start_i = 1'b0;
    for (int c = 0; c < 4000 && !fin; c++) begin
      if (rst_at >= 0 && beat_idx == rst_at) begin
        rst_i   = 1'b1;
        start_i = 1'b0;
        cyc();
        rst_i   = 1'b0;
        aborted = 1'b1;
        fin     = 1'b1;
      end else begin
        tx_ready_i = ($urandom_range(0, 99) < ready_pct);
        if (stall_at >= 0 && beat_idx == stall_at && tx_valid_o === 1'b1 && stall_cnt < 50) begin
          tx_ready_i = 1'b0;
          stall_cnt++;
        end
        rx_valid_i = rnd_rx ? 1'($urandom_range(0, 1)) : 1'b1;
        rx_data_i  = 32'hA0 + 32'(res_idx);
        start_i    = (beat_idx > 0 && beat_idx < 100) ? ($urandom_range(0, 7) == 0) : 1'b0;
        cyc();
        if (stall_at >= 0 && stall_cnt == 50 && beat_idx == stall_at) begin
          chk("stall_issued", 32'(exp_issue), 32'(stall_at + 2));
          chk("stall_head", tx_data_o, src_mem[stall_at]);
          stall_cnt++;
        end
        if (jobs_done != jd0) fin = 1'b1;
      end
    end
    start_i = 1'b0;
    chk("job_end", 32'(fin), 32'd1);
  endtask

  initial begin
    bit ab;
    rst_i       = 1'b1;
    start_i     = 1'b0;
    tx_ready_i  = 1'b0;
    rx_valid_i  = 1'b0;
    rx_data_i   = 32'h0;
    src_rdata_i = 32'h0;
    reset_model();
    for (int i = 0; i < NB; i++) src_mem[i] = 32'(i);
    repeat (3) cyc();
    rst_i = 1'b0;

    // reset state
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ren", 32'(src_ren_o), 32'd0);
    chk("rst_raddr", 32'(src_raddr_o), 32'd0);
    chk("rst_txv", 32'(tx_valid_o), 32'd0);
    chk("rst_txd", tx_data_o, 32'd0);
    chk("rst_rxr", 32'(rx_ready_o), 32'd0);
    chk("rst_wen", 32'(res_wen_o), 32'd0);
    chk("rst_waddr", 32'(res_waddr_o), 32'd0);
    repeat (2) cyc();

    // full-rate job: 2-cycle start-up, 172 back-to-back beats
    run_job(100, -1, -1, 1'b0, ab);
    chk("first_valid_lat", 32'(first_valid_cyc - start_cyc), 32'd2);
    chk("burst_len", 32'(last_fire_cyc - first_valid_cyc), 32'd171);
`ifdef FEEDER_CHECKSUM_EN
    chk("chk_seq", chk_o, exp_chk);
    chk("chk_seq_const", chk_o, 32'h0);
`endif
    repeat (3) cyc();

    // random image, 30% tx ready, random rx valid, spurious starts
    for (int i = 0; i < NB; i++) src_mem[i] = $urandom;
    run_job(30, -1, -1, 1'b1, ab);
`ifdef FEEDER_CHECKSUM_EN
    chk("chk_rand", chk_o, exp_chk);
`endif
    repeat (2) cyc();

    // long tx stall at beat 139
    for (int i = 0; i < NB; i++) src_mem[i] = 32'(i);
    run_job(100, 139, -1, 1'b0, ab);

    // abort by reset at beat 60, restart right away with stale read data present
    run_job(100, -1, 60, 1'b0, ab);
    chk("aborted", 32'(ab), 32'd1);
    chk("abort_txv", 32'(tx_valid_o), 32'd0);
    chk("abort_busy", 32'(busy_o), 32'd0);
    run_job(100, -1, -1, 1'b1, ab);
    repeat (2) cyc();

    // checksum image variant: src[0]=1
    src_mem[0] = 32'h1;
    run_job(60, -1, -1, 1'b0, ab);
    repeat (4) cyc();
`ifdef FEEDER_CHECKSUM_EN
    chk("chk_hold", chk_o, exp_chk);
    chk("chk_one", chk_o, 32'h1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
